dmem_arb: RTL
=============

# dmem_arb

Two-port arbiter that shares the single-port synchronous data memory between the processor's data port (P) and a secondary bus master (D, a loader/DMA engine). It sits between the processor's data-memory signals and the memory instance at the top level, beside the memory-mapped I/O decode. The processor wins by default, and a starvation counter bounds how long D can wait. For each accepted read, a one-entry return tag routes read data back to the requester that issued it.

## Interface
- AW, 16, address width
- DW, 16, data width
- STARVE_LIMIT, 4, consecutive cycles D may wait before it is forced a grant (≥1)
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- p_req / d_req  in  1  request valid
- p_wr / d_wr  in  1  1 = write, 0 = read
- p_addr / d_addr  in  AW  word address
- p_wdata / d_wdata  in  DW  write data
- p_gnt / d_gnt  out  1  request accepted this cycle (combinational)
- p_rvalid / d_rvalid  out  1  read data valid for that requester
- rdata  out  DW  read data, shared, qualified by the rvalid outputs
- mem_en  out  1  memory access strobe
- mem_wr  out  1  memory write enable
- mem_addr  out  AW
- mem_wdata  out  DW
- mem_rdata  in  DW  memory read data, valid one cycle after a read strobe

## Operation
- Handshake: a requester holds req, wr, addr and wdata stable until it sees gnt high in the same cycle. The transfer completes on that edge.
- At most one grant per cycle. The grant is mutually exclusive.
- Arbitration rules:
  - Only P requesting: P is granted.
  - Only D requesting: D is granted.
  - Both requesting: P is granted unless wait_cnt == STARVE_LIMIT, in which case D is granted.
- wait_cnt behaviour:
  - Increments, saturating at STARVE_LIMIT, on each cycle where d_req=1 and d_gnt=0.
  - Clears on any D grant, or when d_req=0.
- Memory command is driven from the granted port in the same cycle.
  - mem_en = p_gnt | d_gnt.
  - mem_wr = granted wr.
  - mem_addr and mem_wdata come from the granted port.
  - With no grant, the memory outputs are 0.
- Read return:
  - A granted read (wr=0) loads the return tag: tag_v=1 and tag_owner = P or D.
  - On the next cycle, the owner's rvalid is 1 and rdata = mem_rdata.
  - Back-to-back reads from either port are allowed. The tag is overwritten every cycle and only one read is outstanding per cycle.
- A write never raises rvalid.
- Outside an rvalid cycle, rdata = mem_rdata and carries no meaning.

## Timing
- Grant latency is 0 cycles: gnt is combinational from req and wait_cnt.
- Read latency is 1 cycle from gnt to rvalid.
- Throughput is 1 access per cycle.
- Worst-case D wait, under continuous P requests, is STARVE_LIMIT cycles. D is granted on cycle STARVE_LIMIT+1 of its request.
- Reset values:
  - wait_cnt = 0, tag_v = 0.
  - All gnt and rvalid outputs = 0.
  - mem_en = 0, mem_wr = 0.
- Reset asserted with a read outstanding: the read is dropped and no rvalid is produced after reset releases.
- wait_cnt width is $clog2(STARVE_LIMIT+1). It never wraps.

## Configuration
- DMEM_ARB_MMIO_GUARD_EN defined:
  - Any granted write with addr[15:12] == 4'hC is still granted (gnt=1) but has mem_wr=0 and mem_en=0. Memory is not disturbed under I/O space.
  - Reads in that range are passed through unchanged; the top-level I/O mux overrides rdata.
- DMEM_ARB_MMIO_GUARD_EN undefined: all granted accesses reach memory unmodified.

## Structure
- Shared package dmem_arb_pkg holds:
  - typedef owner_t enum {OWN_P, OWN_D}.
  - localparam MMIO_PAGE = 4'hC.
  - The default AW, DW and STARVE_LIMIT.
- One sub-module, dmem_arb_starve, holds wait_cnt and produces the force_d flag. Grant logic, the memory mux and the return tag stay in dmem_arb.

## Test plan
- Reset with p_req=1 → all outputs 0. After release, P is granted in the first cycle, mem_en=1.
- P read of addr 0x0010 (memory holds 0xBEEF) → p_gnt in cycle N; p_rvalid=1 and rdata=0xBEEF in N+1; d_rvalid stays 0.
- Both requesting continuously, STARVE_LIMIT=4 → P granted 4 cycles, then D granted 1 cycle, then the pattern repeats; d_gnt and p_gnt are never high together.
- D write 0x1234 to 0x0020 immediately followed by a P read of 0x0020 → p_rvalid with rdata=0x1234.
- With DMEM_ARB_MMIO_GUARD_EN, P write of 0x03FF to 0xC000 → p_gnt=1, mem_en=0; a later read of 0xC000 returns the prior memory content. Without the macro, mem_wr=1.
- D read granted, then rst pulsed the next cycle → d_rvalid stays 0; wait_cnt=0 after release.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and defaults for the data-memory arbiter.
//   owner_t     - which requester a pending read belongs to
//   MMIO_PAGE   - address page [15:12] reserved for memory-mapped I/O
//   Default*    - default address/data widths and starvation limit
package dmem_arb_pkg;

  typedef enum logic {
    OWN_P = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  localparam logic [3:0] MMIO_PAGE = 4'hC;

  localparam int unsigned DefaultAw          = 16;
  localparam int unsigned DefaultDw          = 16;
  localparam int unsigned DefaultStarveLimit = 4;

endpackage

// File: rtl/dmem_arb_if.sv
// dmem_arb_if: bundle of the processor port (p_*), secondary master port (d_*),
// shared read data and the memory command/response signals.
//   slave  modport - arbiter side
//   master modport - requesters plus memory model side (used by the environment)
interface dmem_arb_if #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 16
);
  logic          p_req;
  logic          p_wr;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_wdata;
  logic          p_gnt;
  logic          p_rvalid;

  logic          d_req;
  logic          d_wr;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;

  logic [DW-1:0] rdata;

  logic          mem_en;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  p_req, p_wr, p_addr, p_wdata,
    input  d_req, d_wr, d_addr, d_wdata,
    output p_gnt, p_rvalid, d_gnt, d_rvalid, rdata,
    output mem_en, mem_wr, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output p_req, p_wr, p_addr, p_wdata,
    output d_req, d_wr, d_addr, d_wdata,
    input  p_gnt, p_rvalid, d_gnt, d_rvalid, rdata,
    input  mem_en, mem_wr, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arb_starve.sv
// dmem_arb_starve: counts consecutive cycles the secondary master waits and
// raises force_d once the wait reaches STARVE_LIMIT.
//   clk, rst - clock, asynchronous active-high reset
//   d_req    - secondary master request
//   d_gnt    - secondary master granted this cycle
//   force_d  - wait count has hit the limit; D must win this cycle
module dmem_arb_starve #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic d_req,
  input  logic d_gnt,
  output logic force_d
);

  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] Limit = CntW'(STARVE_LIMIT);

  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!d_req || d_gnt) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != Limit) begin
      // Saturate so the count never wraps back to zero.
      wait_cnt_d = wait_cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign force_d = (wait_cnt_q == Limit);

endmodule

// File: rtl/dmem_arb.sv
// dmem_arb: shares one single-port synchronous data memory between the
// processor data port (P, default winner) and a secondary master (D), with a
// starvation bound on D and a one-entry return tag steering read data back.
//   clk, rst - clock, asynchronous active-high reset
//   bus      - dmem_arb_if.slave: p_*/d_* request ports, gnt/rvalid/rdata
//              responses, mem_* command and mem_rdata response
// Optional build macro DMEM_ARB_MMIO_GUARD_EN: granted writes into the MMIO
// page (addr[15:12] == 4'hC) are accepted but never reach the memory.
module dmem_arb
  import dmem_arb_pkg::*;
#(
  parameter int unsigned AW           = DefaultAw,
  parameter int unsigned DW           = DefaultDw,
  parameter int unsigned STARVE_LIMIT = DefaultStarveLimit
) (
  input logic        clk,
  input logic        rst,
  dmem_arb_if.slave  bus
);

  logic          force_d;
  logic          p_gnt, d_gnt, any_gnt;
  logic          sel_wr;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          block_wr;
  logic          tag_v_q, tag_v_d;
  owner_t        tag_owner_q, tag_owner_d;

  dmem_arb_starve #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk    (clk),
    .rst    (rst),
    .d_req  (bus.d_req),
    .d_gnt  (d_gnt),
    .force_d(force_d)
  );

  // Grants are held low while reset is asserted so nothing is accepted.
  always_comb begin
    p_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!rst) begin
      if (bus.d_req && (!bus.p_req || force_d)) begin
        d_gnt = 1'b1;
      end else if (bus.p_req) begin
        p_gnt = 1'b1;
      end
    end
  end

  assign any_gnt = p_gnt | d_gnt;

  always_comb begin
    sel_wr    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    if (d_gnt) begin
      sel_wr    = bus.d_wr;
      sel_addr  = bus.d_addr;
      sel_wdata = bus.d_wdata;
    end else if (p_gnt) begin
      sel_wr    = bus.p_wr;
      sel_addr  = bus.p_addr;
      sel_wdata = bus.p_wdata;
    end
  end

`ifdef DMEM_ARB_MMIO_GUARD_EN
  // Writes to I/O space are acknowledged but kept off the memory.
  assign block_wr = sel_wr && (sel_addr[AW-1 -: 4] == MMIO_PAGE);
`else
  assign block_wr = 1'b0;
`endif

  assign bus.mem_en    = any_gnt & ~block_wr;
  assign bus.mem_wr    = sel_wr & ~block_wr;
  assign bus.mem_addr  = sel_addr;
  assign bus.mem_wdata = sel_wdata;

  // Return tag: rewritten every cycle, so only the latest read is tracked.
  always_comb begin
    tag_v_d     = any_gnt & ~sel_wr;
    tag_owner_d = d_gnt ? OWN_D : OWN_P;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_v_q     <= 1'b0;
      tag_owner_q <= OWN_P;
    end else begin
      tag_v_q     <= tag_v_d;
      tag_owner_q <= tag_owner_d;
    end
  end

  assign bus.p_gnt    = p_gnt;
  assign bus.d_gnt    = d_gnt;
  assign bus.p_rvalid = tag_v_q && (tag_owner_q == OWN_P);
  assign bus.d_rvalid = tag_v_q && (tag_owner_q == OWN_D);
  assign bus.rdata    = bus.mem_rdata;

endmodule
